// File: rtl/adpll_pkg.sv
// adpll_pkg: shared encodings and constants
// for the ADPLL loop controller.
package adpll_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SEARCH = 2'd1,
    S_TRACK  = 2'd2
  } state_t;

  // Read as 2-bit signed, the encodings are 0, +1 and -1.
  typedef enum logic [1:0] {
    DEC_ZERO = 2'b00,
    DEC_UP   = 2'b01,
    DEC_DN   = 2'b11
  } dec_t;

  localparam int CODE_MAX_DEF  = 128;
  localparam int CODE_INIT_DEF = 64;
  localparam logic [5:0] STEP_INIT = 6'd32;

  function automatic logic signed [8:0] dec_scale(
    input dec_t       d,
    input logic [5:0] mag
  );
    logic signed [8:0] v;
    v = '0;
    unique case (d)
      DEC_UP:  v = $signed({3'b000, mag});
      DEC_DN:  v = -$signed({3'b000, mag});
      default: v = '0;
    endcase
    return v;
  endfunction

endpackage

// File: rtl/adpll_win_acc.sv
// adpll_win_acc: fixed-length window counter and
// saturating up/dn accumulator producing one decision per window.
module adpll_win_acc
  import adpll_pkg::*;
#(
  parameter int WIN   = 16,
  parameter int ACC_W = 6
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_run,
  input  logic i_up,
  input  logic i_dn,
  output logic o_dv,
  output dec_t o_dec
);

  localparam int CW = $clog2(WIN);
  localparam logic [CW-1:0] LAST = CW'(WIN - 1);
  localparam logic signed [ACC_W:0] SMAX =
    (ACC_W+1)'((1 << (ACC_W - 1)) - 1);
  localparam logic signed [ACC_W:0] SMIN = -SMAX;

  logic [CW-1:0]           r_cnt;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [ACC_W:0]   w_delta;
  logic signed [ACC_W:0]   w_sum;
  logic signed [ACC_W-1:0] w_acc;

  always_comb begin
    w_delta = '0;
    if (i_up && !i_dn)
      w_delta = (ACC_W+1)'(1);
    else if (i_dn && !i_up)
      w_delta = '1;
    w_sum = {r_acc[ACC_W-1], r_acc} + w_delta;
    if (w_sum > SMAX)
      w_acc = SMAX[ACC_W-1:0];
    else if (w_sum < SMIN)
      w_acc = SMIN[ACC_W-1:0];
    else
      w_acc = w_sum[ACC_W-1:0];
  end

  // The last cycle's pulse is folded in before deciding.
  always_comb begin
    o_dv  = i_run && (r_cnt == LAST);
    o_dec = DEC_ZERO;
    if (w_acc[ACC_W-1])
      o_dec = DEC_DN;
    else if (w_acc != '0)
      o_dec = DEC_UP;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else if (!i_run || r_cnt == LAST) begin
      r_cnt <= '0;
      r_acc <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
      r_acc <= w_acc;
    end
  end

endmodule

// File: rtl/adpll_loop_ctrl.sv
// adpll_loop_ctrl: SAR coarse search then +/-1 tracking
// with lock detection, driving the DCO thermometer code.
module adpll_loop_ctrl
  import adpll_pkg::*;
#(
  parameter int WIN       = 16,
  parameter int ACC_W     = 6,
  parameter int LOCK_WIN  = 4,
  parameter int CODE_INIT = CODE_INIT_DEF,
  parameter int CODE_MAX  = CODE_MAX_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       pfd_up,
  input  logic       pfd_dn,
  output logic [7:0] dco_code,
  output logic       lock,
  output logic [1:0] state
);

  localparam int LCW = $clog2(LOCK_WIN + 1);
  localparam logic [LCW-1:0] LFULL = LCW'(LOCK_WIN);
  localparam logic signed [8:0] CMAX = 9'(CODE_MAX);

  state_t            r_state, n_state;
  logic [7:0]        r_code, n_code;
  logic [5:0]        r_step, n_step;
  logic [LCW-1:0]    r_lcnt, n_lcnt;
  dec_t              r_prev, n_prev;
  logic              r_lock, n_lock;

  logic              w_dv;
  dec_t              w_dec;
  logic [5:0]        w_mag;
  logic signed [8:0] w_sum;
  logic [7:0]        w_clamp;

  adpll_win_acc #(
    .WIN   (WIN),
    .ACC_W (ACC_W)
  ) u_win (
    .clk   (clk),
    .rst_n (reset),
    .i_run (enable && (r_state != S_IDLE)),
    .i_up  (pfd_up),
    .i_dn  (pfd_dn),
    .o_dv  (w_dv),
    .o_dec (w_dec)
  );

  always_comb begin
    w_mag = (r_state == S_SEARCH) ? r_step : 6'd1;
    w_sum = $signed({1'b0, r_code}) + dec_scale(w_dec, w_mag);
    if (w_sum < 0)
      w_clamp = 8'd0;
    else if (w_sum > CMAX)
      w_clamp = CMAX[7:0];
    else
      w_clamp = w_sum[7:0];
  end

  always_comb begin
    n_state = r_state;
    n_code  = r_code;
    n_step  = r_step;
    n_lcnt  = r_lcnt;
    n_prev  = r_prev;
    n_lock  = r_lock;
    if (!enable) begin
      n_state = S_IDLE;
      n_code  = 8'(CODE_INIT);
      n_step  = STEP_INIT;
      n_lcnt  = '0;
      n_prev  = DEC_ZERO;
      n_lock  = 1'b0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          n_state = S_SEARCH;
          n_step  = STEP_INIT;
        end
        S_SEARCH: if (w_dv) begin
          n_code = w_clamp;
          n_step = r_step >> 1;
          if (r_step == 6'd1) begin
            n_state = S_TRACK;
            n_lcnt  = '0;
            n_prev  = DEC_ZERO;
            n_lock  = 1'b0;
          end
        end
        S_TRACK: if (w_dv) begin
          n_code = w_clamp;
          // A repeated nonzero direction means we are still slewing.
          if (w_dec != DEC_ZERO && w_dec == r_prev) begin
            n_lcnt = '0;
            n_lock = 1'b0;
          end else begin
            if (r_lcnt != LFULL)
              n_lcnt = r_lcnt + 1'b1;
            n_lock = (n_lcnt == LFULL);
          end
          if (w_dec != DEC_ZERO)
            n_prev = w_dec;
        end
        default: n_state = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= S_IDLE;
      r_code  <= 8'(CODE_INIT);
      r_step  <= STEP_INIT;
      r_lcnt  <= '0;
      r_prev  <= DEC_ZERO;
      r_lock  <= 1'b0;
    end else begin
      r_state <= n_state;
      r_code  <= n_code;
      r_step  <= n_step;
      r_lcnt  <= n_lcnt;
      r_prev  <= n_prev;
      r_lock  <= n_lock;
    end
  end

  assign dco_code = r_code;
  assign lock     = r_lock;
  assign state    = r_state;

endmodule

// File: tb/tb_adpll_loop_ctrl.sv
// tb_adpll_loop_ctrl: directed and randomized checks of the
// loop controller against a window-level reference model.
module tb_adpll_loop_ctrl;

  localparam int WIN   = 16;
  localparam int ACC_W = 6;
  localparam int LWIN  = 4;
  localparam int AMAX  = (1 << (ACC_W - 1)) - 1;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       up = 1'b0;
  logic       dn = 1'b0;
  logic [7:0] dco_code;
  logic       lock;
  logic [1:0] state;

  int n_chk = 0;
  int n_err = 0;

  int m_state = 0;
  int m_code  = 64;
  int m_lock  = 0;
  int m_acc   = 0;
  int m_pos   = 0;
  int m_step  = 32;
  int m_lcnt  = 0;
  int m_prev  = 0;

  adpll_loop_ctrl #(
    .WIN      (WIN),
    .ACC_W    (ACC_W),
    .LOCK_WIN (LWIN)
  ) dut (
    .clk      (clk),
    .reset    (rst_n),
    .enable   (en),
    .pfd_up   (up),
    .pfd_dn   (dn),
    .dco_code (dco_code),
    .lock     (lock),
    .state    (state)
  );

  always #5 clk = ~clk;

  function automatic void chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               nm, act, exp, $time);
    end
  endfunction

  function automatic int clampc(int v);
    if (v < 0) return 0;
    if (v > 128) return 128;
    return v;
  endfunction

  function automatic void m_idle();
    m_state = 0; m_code = 64; m_lock = 0;
    m_acc = 0; m_pos = 0; m_step = 32;
    m_lcnt = 0; m_prev = 0;
  endfunction

  function automatic void m_decide(int d);
    if (m_state == 1) begin
      m_code = clampc(m_code + d * m_step);
      if (m_step == 1) begin
        m_state = 2; m_lcnt = 0; m_prev = 0; m_lock = 0;
      end
      m_step = m_step / 2;
    end else begin
      m_code = clampc(m_code + d);
      if (d != 0 && d == m_prev) begin
        m_lcnt = 0; m_lock = 0;
      end else begin
        m_lcnt = (m_lcnt + 1 > LWIN) ? LWIN : m_lcnt + 1;
        m_lock = (m_lcnt == LWIN) ? 1 : 0;
      end
      if (d != 0) m_prev = d;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_idle();
    end else if (!en) begin
      m_idle();
    end else if (m_state == 0) begin
      m_state = 1; m_step = 32; m_pos = 0; m_acc = 0;
    end else begin
      m_acc += int'(up) - int'(dn);
      if (m_acc > AMAX) m_acc = AMAX;
      if (m_acc < -AMAX) m_acc = -AMAX;
      if (m_pos == WIN - 1) begin
        m_decide((m_acc > 0) ? 1 : (m_acc < 0) ? -1 : 0);
        m_acc = 0;
        m_pos = 0;
      end else begin
        m_pos++;
      end
    end
  end

  always @(negedge clk) begin
    chk("model_code", dco_code, m_code);
    chk("model_lock", lock, m_lock);
    chk("model_state", state, m_state);
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic e, input logic u, input logic d);
    en = e; up = u; dn = d;
    tick();
  endtask

  task automatic win(input logic u, input logic d);
    repeat (WIN) drive(1'b1, u, d);
  endtask

  task automatic start();
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
  endtask

  int exp_up[6] = '{96, 112, 120, 124, 126, 127};
  int exp_dn[6] = '{32, 16, 8, 4, 2, 1};
  int bias;

  initial begin
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 40; i++)
      drive(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    chk("idle_code", dco_code, 64);
    chk("idle_state", state, 0);
    chk("idle_lock", lock, 0);

    start();
    for (int w = 0; w < 6; w++) begin
      win(1'b1, 1'b0);
      chk("up_search_code", dco_code, exp_up[w]);
    end
    chk("up_track_state", state, 2);
    win(1'b1, 1'b0);
    chk("up_top_code", dco_code, 128);
    win(1'b1, 1'b0);
    chk("up_no_wrap", dco_code, 128);

    start();
    for (int w = 0; w < 6; w++) begin
      win(1'b0, 1'b1);
      chk("dn_search_code", dco_code, exp_dn[w]);
    end
    win(1'b0, 1'b1);
    chk("dn_floor_code", dco_code, 0);
    win(1'b0, 1'b1);
    chk("dn_no_wrap", dco_code, 0);

    start();
    win(1'b1, 1'b0);
    win(1'b0, 1'b0);
    win(1'b1, 1'b0);
    win(1'b0, 1'b1);
    win(1'b0, 1'b0);
    win(1'b0, 1'b0);
    chk("t100_code", dco_code, 100);
    chk("t100_state", state, 2);
    win(1'b1, 1'b0);
    chk("dither1", dco_code, 101);
    win(1'b0, 1'b1);
    chk("dither2", dco_code, 100);
    win(1'b1, 1'b0);
    chk("dither3", dco_code, 101);
    chk("dither3_lock", lock, 0);
    win(1'b0, 1'b1);
    chk("dither4", dco_code, 100);
    chk("dither4_lock", lock, 1);
    win(1'b1, 1'b0);
    chk("slew1_lock", lock, 1);
    win(1'b1, 1'b0);
    chk("slew2_code", dco_code, 102);
    chk("slew2_lock", lock, 0);

    start();
    for (int w = 0; w < 6; w++) win(1'b1, 1'b1);
    chk("zero_code", dco_code, 64);
    chk("zero_state", state, 2);
    for (int w = 0; w < 3; w++) win(1'b1, 1'b1);
    chk("zero_lock3", lock, 0);
    win(1'b1, 1'b1);
    chk("zero_lock4", lock, 1);

    drive(1'b0, 1'b1, 1'b0);
    chk("drop_code", dco_code, 64);
    chk("drop_state", state, 0);
    chk("drop_lock", lock, 0);

    start();
    win(1'b1, 1'b0);
    win(1'b0, 1'b1);
    repeat (5) drive(1'b1, 1'b1, 1'b0);
    #1;
    rst_n = 1'b0;
    #1;
    chk("arst_code", dco_code, 64);
    chk("arst_state", state, 0);
    tick();
    rst_n = 1'b1;
    tick();

    for (int s = 0; s < 40; s++) begin
      bias = $urandom_range(0, 100);
      for (int c = 0; c < 100; c++) begin
        drive(1'($urandom_range(0, 299) != 0),
              1'($urandom_range(0, 99) < bias),
              1'($urandom_range(0, 99) < 100 - bias));
      end
    end

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule
